btn_chord_encoder: RTL and testbench

BTN_CHORD_ENCODER -- requirements
Module: btn_chord_encoder

---
 rtl/btn_pkg.sv | 13 +
 rtl/debounce_bit.sv | 45 ++++
 rtl/btn_chord_encoder.sv | 77 +++++++
 tb/tb_btn_chord_encoder.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared definitions for the push-button chord encoder: FSM encoding and
// the default debounce interval (10 ms at 100 MHz).
package btn_pkg;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    EMIT    = 2'd2
  } state_t;

endpackage

// File: rtl/debounce_bit.sv
// One push-button bit: 2-flop synchronizer followed by a stability counter
// that only lets the debounced level follow after DEBOUNCE_CYCLES steady cycles.
module debounce_bit
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic db
);

  localparam logic [CNT_W:0] TERM = (CNT_W+1)'(DEBOUNCE_CYCLES);

  logic             meta;
  logic             sync;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W:0]   cnt_inc;

  // One extra bit so the terminal compare cannot wrap when TERM == 2^CNT_W.
  assign cnt_inc = {1'b0, cnt} + (CNT_W+1)'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
      cnt  <= '0;
      db   <= 1'b0;
    end else begin
      meta <= raw;
      sync <= meta;
      if (sync == db) begin
        cnt <= '0;
      end else if (cnt_inc == TERM) begin
        db  <= sync;
        cnt <= '0;
      end else begin
        cnt <= cnt_inc[CNT_W-1:0];
      end
    end
  end

endmodule

// File: rtl/btn_chord_encoder.sv
// Debounces four push-buttons and reports each chord (OR of everything
// pressed between first press and full release) as a single-cycle code.
//
// state   | meaning
// IDLE    | no button debounced-high; chord register held at zero
// COLLECT | at least one button down; OR-ing debounced buttons into chord
// EMIT    | chord presented on btns for this one cycle
module btn_chord_encoder
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] btn_raw,
  output logic [3:0] btns,
  output logic       busy
);

  logic [3:0] db;
  logic [3:0] chord;
  state_t     state;

  for (genvar i = 0; i < 4; i++) begin : g_db
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_debounce (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (btn_raw[i]),
      .db   (db[i])
    );
  end

  // db is ignored during EMIT; a press landing there is seen from IDLE next cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      chord <= '0;
      btns  <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          btns  <= '0;
          chord <= db;
          if (db != 4'b0000) begin
            state <= COLLECT;
            busy  <= 1'b1;
          end
        end
        COLLECT: begin
          chord <= chord | db;
          if (db == 4'b0000) begin
            state <= EMIT;
            busy  <= 1'b0;
            btns  <= chord;
          end
        end
        EMIT: begin
          btns  <= '0;
          chord <= '0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          chord <= '0;
          btns  <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_btn_chord_encoder.sv
// Directed chord scenarios plus random button activity, checked every cycle
// against a behavioural model and per-scenario against the expected pulses.
module tb_btn_chord_encoder;

  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] btn_raw = 4'b0000;
  logic [3:0] btns;
  logic       busy;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [3:0] pulses[$];
  int         pulse_cyc[$];

  // reference model state
  logic [3:0] m_s1, m_s2, m_db;
  logic [3:0] m_hist[DEB];
  bit         m_collect, m_emit;
  logic [3:0] m_acc, m_btns;

  btn_chord_encoder #(.DEBOUNCE_CYCLES(DEB), .CNT_W(3)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_raw(btn_raw),
    .btns   (btns),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    m_s1 = '0; m_s2 = '0; m_db = '0;
    for (int i = 0; i < DEB; i++) m_hist[i] = '0;
    m_collect = 0; m_emit = 0; m_acc = '0; m_btns = '0;
  endtask

  // Advances the model by one clock edge with the inputs sampled on that edge.
  task automatic model_step(input logic [3:0] raw, input logic rstn);
    bit all_diff;
    if (!rstn) begin
      model_clear();
      return;
    end
    if (m_emit) begin
      m_emit = 0; m_btns = '0; m_acc = '0;
    end else if (m_collect) begin
      m_acc = m_acc | m_db;
      if (m_db == 4'b0000) begin
        m_collect = 0; m_emit = 1; m_btns = m_acc;
      end
    end else if (m_db != 4'b0000) begin
      m_collect = 1; m_acc = m_db;
    end
    // a debounced bit flips once the last DEB synchronized samples all disagree with it
    for (int i = DEB - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = m_s2;
    for (int b = 0; b < 4; b++) begin
      all_diff = 1;
      for (int i = 0; i < DEB; i++) if (m_hist[i][b] == m_db[b]) all_diff = 0;
      if (all_diff) m_db[b] = ~m_db[b];
    end
    m_s2 = m_s1;
    m_s1 = raw;
  endtask

  task automatic tick(input logic [3:0] raw, input logic rstn);
    @(negedge clk);
    n_chk++;
    assert (btns === m_btns) else begin
      n_fail++;
      $error("FAIL btns cyc=%0d observed=%b expected=%b", cyc, btns, m_btns);
    end
    n_chk++;
    assert (busy === m_collect) else begin
      n_fail++;
      $error("FAIL busy cyc=%0d observed=%b expected=%b", cyc, busy, m_collect);
    end
    if (btns !== 4'b0000) begin
      pulses.push_back(btns);
      pulse_cyc.push_back(cyc);
    end
    btn_raw = raw;
    rst_n   = rstn;
    model_step(raw, rstn);
    cyc++;
  endtask

  task automatic hold(input logic [3:0] raw, input int n);
    for (int i = 0; i < n; i++) tick(raw, 1'b1);
  endtask

  task automatic start_scenario();
    pulses.delete();
    pulse_cyc.delete();
  endtask

  task automatic check_pulses(input string tag, input int cnt, input logic [3:0] v0,
                              input logic [3:0] v1);
    n_chk++;
    assert (pulses.size() == cnt) else begin
      n_fail++;
      $error("FAIL %s pulse_count observed=%0d expected=%0d", tag, pulses.size(), cnt);
    end
    if (cnt >= 1 && pulses.size() >= 1) begin
      n_chk++;
      assert (pulses[0] === v0) else begin
        n_fail++;
        $error("FAIL %s pulse0 observed=%b expected=%b", tag, pulses[0], v0);
      end
    end
    if (cnt >= 2 && pulses.size() >= 2) begin
      n_chk++;
      assert (pulses[1] === v1) else begin
        n_fail++;
        $error("FAIL %s pulse1 observed=%b expected=%b", tag, pulses[1], v1);
      end
    end
  endtask

  initial begin
    int rel;
    int left;
    logic [3:0] r;
    logic       rn;

    model_clear();

    // reset state
    start_scenario();
    for (int i = 0; i < 3; i++) tick(4'b0000, 1'b0);
    hold(4'b0000, 5);
    check_pulses("reset", 0, 4'b0000, 4'b0000);

    // single press: pulse exactly 7 cycles after release
    start_scenario();
    hold(4'b0001, 20);
    rel = cyc;
    hold(4'b0000, 15);
    check_pulses("single", 1, 4'b0001, 4'b0000);
    if (pulse_cyc.size() >= 1) begin
      n_chk++;
      assert (pulse_cyc[0] - rel == 7) else begin
        n_fail++;
        $error("FAIL single_latency observed=%0d expected=7", pulse_cyc[0] - rel);
      end
    end

    // chord with partial release
    start_scenario();
    hold(4'b0100, 10);
    hold(4'b0101, 10);
    hold(4'b0001, 10);
    hold(4'b0000, 15);
    check_pulses("chord", 1, 4'b0101, 4'b0000);

    // bounce: toggling shorter than the debounce window never debounces
    start_scenario();
    for (int i = 0; i < 30; i++) begin
      tick(((i / 2) % 2 == 0) ? 4'b0010 : 4'b0000, 1'b1);
      n_chk++;
      assert (busy === 1'b0) else begin
        n_fail++;
        $error("FAIL bounce_busy cyc=%0d observed=%b expected=0", cyc, busy);
      end
    end
    hold(4'b0010, 20);
    hold(4'b0000, 15);
    check_pulses("bounce", 1, 4'b0010, 4'b0000);

    // reset mid-chord aborts, then a re-press emits once
    start_scenario();
    hold(4'b1010, 12);
    tick(4'b1010, 1'b0);
    hold(4'b1010, 3);
    hold(4'b0000, 15);
    check_pulses("reset_abort", 0, 4'b0000, 4'b0000);
    start_scenario();
    hold(4'b1010, 15);
    hold(4'b0000, 15);
    check_pulses("repress", 1, 4'b1010, 4'b0000);

    // back-to-back: bit1 debounces high in the EMIT cycle
    start_scenario();
    hold(4'b0001, 20);
    hold(4'b0000, 1);
    hold(4'b0010, 15);
    hold(4'b0000, 15);
    check_pulses("back_to_back", 2, 4'b0001, 4'b0010);

    // held through reset release
    start_scenario();
    for (int i = 0; i < 3; i++) tick(4'b0001, 1'b0);
    hold(4'b0001, 20);
    hold(4'b0000, 15);
    check_pulses("held_reset", 1, 4'b0001, 4'b0000);

    // random activity including occasional resets, checked against the model
    for (int k = 0; k < 600; ) begin
      r    = 4'($urandom_range(0, 15));
      left = $urandom_range(1, 12);
      for (int j = 0; j < left; j++) begin
        rn = ($urandom_range(0, 39) != 0);
        tick(r, rn);
        k++;
      end
    end
    hold(4'b0000, 15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
